// File: rtl/ieee_settle_pkg.sv
// Shared types and FP32 helpers for the settle monitor.
package ieee_settle_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SKIP    = 2'd1,
      MEASURE = 2'd2,
      REPORT  = 2'd3
   } state_t;

   localparam int FP32_SIGN_BIT = 31;
   localparam int FP32_EXP_MSB  = 30;
   localparam int FP32_EXP_LSB  = 23;
   localparam int FP32_MAN_MSB  = 22;
   localparam int FP32_MAN_LSB  = 0;

   function automatic logic fp32_is_nan(input logic [31:0] w);
      logic res;
      res = (w[FP32_EXP_MSB:FP32_EXP_LSB] == 8'hFF) &&
            (w[FP32_MAN_MSB:FP32_MAN_LSB] != 23'd0);
      return res;
   endfunction

   // Magnitudes of same-signed finite floats are monotonic in their low 31 bits,
   // so the integer distance between them is the ULP distance.
   function automatic logic fp32_ulp_equal(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [7:0]  tol);
      logic [30:0] mag_a;
      logic [30:0] mag_b;
      logic [30:0] diff;
      logic        res;
      mag_a = a[FP32_EXP_MSB:0];
      mag_b = b[FP32_EXP_MSB:0];
      diff  = (mag_a >= mag_b) ? (mag_a - mag_b) : (mag_b - mag_a);
      if (fp32_is_nan(a) || fp32_is_nan(b))
         res = 1'b0;
      else if ((mag_a == 31'd0) && (mag_b == 31'd0))
         res = 1'b1;
      else if (a[FP32_SIGN_BIT] != b[FP32_SIGN_BIT])
         res = 1'b0;
      else
         res = (diff <= {23'd0, tol});
      return res;
   endfunction

endpackage

// File: rtl/settle_channel.sv
// One monitored channel: previous sample, current equal-run and longest run.
module settle_channel
   import ieee_settle_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample,
   input  logic              clear,
   input  logic              load,
   input  logic              mode,
   input  logic [7:0]        tol,
   input  logic [DATA_W-1:0] data,
   output logic [CNT_W-1:0]  max_run
);

   logic [DATA_W-1:0] prev;
   logic              prev_vld;
   logic [CNT_W-1:0]  run;
   logic [CNT_W-1:0]  run_nxt;
   logic              equal;

   // Compare against the previous sample and form the saturating next run.
   always_comb begin
      equal   = mode ? fp32_ulp_equal(data, prev, tol) : (data == prev);
      run_nxt = '0;
      if (equal) begin
         if (run == '1)
            run_nxt = run;
         else
            run_nxt = run + CNT_W'(1);
      end
   end

   // Channel state: clear on start, prime prev at end of skip, track runs while measuring.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         prev     <= '0;
         prev_vld <= 1'b0;
         run      <= '0;
         max_run  <= '0;
      end else if (load) begin
         prev     <= data;
         prev_vld <= 1'b1;
      end else if (sample && prev_vld) begin
         prev <= data;
         run  <= run_nxt;
         if (run_nxt > max_run)
            max_run <= run_nxt;
      end
   end

endmodule

// File: rtl/ieee_settle_monitor.sv
// Multi-channel FP32 settle detector: skip, measure a window, report verdicts.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; sample_en ignored
//   SKIP    | discarding SKIP_SAMPLES strobes; last one primes prev
//   MEASURE | comparing each strobe against prev for WINDOW strobes
//   REPORT  | one cycle; verdicts and max_run latched, done pulsed
module ieee_settle_monitor
   import ieee_settle_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int DATA_W       = 32,
   parameter int SKIP_SAMPLES = 8,
   parameter int WINDOW       = 400,
   parameter int THRESH       = 20,
   parameter int CNT_W        = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sample_en,
   input  logic [NUM_CH*DATA_W-1:0] data_in,
   input  logic                     start,
   input  logic                     cmp_mode,
   input  logic [7:0]               ulp_tol,
   output logic                     busy,
   output logic                     done,
   output logic [NUM_CH-1:0]        stable,
   output logic [NUM_CH*CNT_W-1:0]  max_run
);

   state_t                  state;
   state_t                  state_nxt;
   logic [7:0]              skip_cnt;
   logic [CNT_W-1:0]        win_cnt;
   logic                    mode_q;
   logic [7:0]              tol_q;
   logic                    start_acc;
   logic                    ch_load;
   logic                    ch_sample;
   logic                    skip_last;
   logic                    win_last;
   logic [NUM_CH*CNT_W-1:0] ch_max;

   assign skip_last = (skip_cnt == 8'(SKIP_SAMPLES - 1));
   assign win_last  = (win_cnt == CNT_W'(WINDOW - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and per-cycle channel controls.
   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      ch_load   = 1'b0;
      ch_sample = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nxt = SKIP;
            end
         end
         SKIP: begin
            if (sample_en && skip_last) begin
               ch_load   = 1'b1;
               state_nxt = MEASURE;
            end
         end
         MEASURE: begin
            ch_sample = sample_en;
            if (sample_en && win_last)
               state_nxt = REPORT;
         end
         REPORT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Skip/window counters and the compare settings captured at start.
   always_ff @(posedge clk) begin
      if (reset) begin
         skip_cnt <= '0;
         win_cnt  <= '0;
         mode_q   <= 1'b0;
         tol_q    <= '0;
      end else if (start_acc) begin
         skip_cnt <= '0;
         win_cnt  <= '0;
         mode_q   <= cmp_mode;
         tol_q    <= ulp_tol;
      end else if (sample_en && (state == SKIP)) begin
         skip_cnt <= skip_cnt + 8'd1;
      end else if (sample_en && (state == MEASURE)) begin
         win_cnt <= win_cnt + CNT_W'(1);
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      settle_channel #(
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .sample  (ch_sample),
         .clear   (start_acc),
         .load    (ch_load),
         .mode    (mode_q),
         .tol     (tol_q),
         .data    (data_in[k*DATA_W +: DATA_W]),
         .max_run (ch_max[k*CNT_W +: CNT_W])
      );
   end

   // Status flags and verdict latch; verdicts move only with done.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         stable  <= '0;
         max_run <= '0;
      end else begin
         done <= 1'b0;
         if (start_acc)
            busy <= 1'b1;
         if (state == REPORT) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            max_run <= ch_max;
            for (int k = 0; k < NUM_CH; k++)
               stable[k] <= (ch_max[k*CNT_W +: CNT_W] >= CNT_W'(THRESH));
         end
      end
   end

endmodule
